// File: rtl/selftrigger_readout_arbiter_pkg.sv
// Shared types and defaults for the self-trigger readout arbiter.
// Optional feature macro used by this block: SELFTRIG_TIMESTAMP_EN.
package selftrigger_pkg;

   localparam int NCH_DEFAULT  = 8;
   localparam int DT_W_DEFAULT = 16;
   localparam int MISS_W       = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      BUSY = 2'd2
   } state_t;

endpackage

// File: rtl/selftrigger_readout_arbiter_if.sv
// Readout request/grant handshake between the arbiter and the shared readout engine.
// SELFTRIG_TIMESTAMP_EN adds the 64-bit rd_ts field carrying the granted trigger's timestamp.
interface selftrigger_readout_arbiter_if
   import selftrigger_pkg::*;
#(
   parameter int NCH = NCH_DEFAULT
);
   localparam int CH_W = $clog2(NCH);

   logic            rd_req;
   logic [CH_W-1:0] rd_ch;
   logic            rd_ack;
   logic            rd_done;
`ifdef SELFTRIG_TIMESTAMP_EN
   logic [63:0]     rd_ts;

   modport master (output rd_req, output rd_ch, output rd_ts, input rd_ack, input rd_done);
   modport slave  (input rd_req, input rd_ch, input rd_ts, output rd_ack, output rd_done);
`else
   modport master (output rd_req, output rd_ch, input rd_ack, input rd_done);
   modport slave  (input rd_req, input rd_ch, output rd_ack, output rd_done);
`endif

endinterface

// File: rtl/selftrigger_readout_arbiter_rr_select.sv
// Combinational round-robin finder: first set request bit at or above ptr, wrapping.
module rr_priority_select #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] idx,
   output logic         valid
);

   logic [W-1:0] cand;

   // Scan from the farthest offset down so the nearest set bit is the last write.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      idx  = '0;
      cand = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = ptr + W'(k);
         if (req[cand]) idx = cand;
      end
   end

   assign valid = |req;

endmodule

// File: rtl/selftrigger_readout_arbiter.sv
// Self-trigger readout arbiter: edge-detects channel triggers, tracks pending/deadtime, grants one channel at a time.
// Define SELFTRIG_TIMESTAMP_EN to capture a per-channel timestamp and present it on rd_ts.
module selftrigger_readout_arbiter
   import selftrigger_pkg::*;
#(
   parameter int NCH  = NCH_DEFAULT,
   parameter int DT_W = DT_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [NCH-1:0]        trig_in,
   input  logic [NCH-1:0]        ch_enable,
   input  logic [DT_W-1:0]       deadtime,
   input  logic [63:0]           timestamp,
   selftrigger_readout_arbiter_if.master rd,
   output logic [NCH-1:0]        pending,
   output logic [MISS_W-1:0]     missed_cnt
);
   localparam int CH_W = $clog2(NCH);

   logic [NCH-1:0]    trig_q;
   logic [NCH-1:0]    trig_edge;
   logic [NCH-1:0]    accept;
   logic [NCH-1:0]    missed_ev;
   logic [NCH-1:0]    grant_clr;
   logic [DT_W-1:0]   dt_cnt [NCH];
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   sel_idx;
   logic              sel_valid;
   logic [MISS_W:0]   miss_sum;
   logic [MISS_W-1:0] miss_next;
   state_t            state;

   assign trig_edge = trig_in & ~trig_q;

   // Holdoff silently swallows an edge; an edge on an idle-deadtime but pending channel is a loss.
   always_comb begin
      accept    = '0;
      missed_ev = '0;
      for (int i = 0; i < NCH; i++) begin
         if (trig_edge[i] && dt_cnt[i] == '0) begin
            if (pending[i])                   missed_ev[i] = 1'b1;
            else if (enable && ch_enable[i])  accept[i]    = 1'b1;
         end
      end
   end

   // Several channels can lose an edge in the same cycle; each one counts.
   always_comb begin
      miss_sum = {1'b0, missed_cnt};
      for (int i = 0; i < NCH; i++)
         miss_sum = miss_sum + {{MISS_W{1'b0}}, missed_ev[i]};
      miss_next = miss_sum[MISS_W] ? '1 : miss_sum[MISS_W-1:0];
   end

   assign grant_clr = (state == IDLE && sel_valid) ? ({{(NCH-1){1'b0}}, 1'b1} << sel_idx) : '0;

   rr_priority_select #(.N(NCH)) u_rr_select (
      .req   (pending),
      .ptr   (rr_ptr),
      .idx   (sel_idx),
      .valid (sel_valid)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         trig_q     <= '0;
         pending    <= '0;
         missed_cnt <= '0;
         for (int i = 0; i < NCH; i++) dt_cnt[i] <= '0;
      end else begin
         trig_q     <= trig_in;
         pending    <= (pending & ~grant_clr) | accept;
         missed_cnt <= miss_next;
         for (int i = 0; i < NCH; i++) begin
            if (accept[i])             dt_cnt[i] <= deadtime;
            else if (dt_cnt[i] != '0)  dt_cnt[i] <= dt_cnt[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rd.rd_req <= 1'b0;
         rd.rd_ch  <= '0;
         rr_ptr    <= '0;
      end else begin
         case (state)
            IDLE: if (sel_valid) begin
               rd.rd_ch  <= sel_idx;
               rd.rd_req <= 1'b1;
               state     <= REQ;
            end
            REQ: if (rd.rd_ack) begin
               rd.rd_req <= 1'b0;
               state     <= BUSY;
            end
            BUSY: if (rd.rd_done) begin
               rr_ptr <= rd.rd_ch + 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SELFTRIG_TIMESTAMP_EN
   logic [63:0] ts_reg [NCH];

   // NOTE: ts_reg is left unreset; an entry is only read after an acceptance has written it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++)
         if (accept[i]) ts_reg[i] <= timestamp;
   end

   always_ff @(posedge clk) begin
      if (reset)                          rd.rd_ts <= '0;
      else if (state == IDLE && sel_valid) rd.rd_ts <= ts_reg[sel_idx];
      else if (state == REQ && rd.rd_ack)  rd.rd_ts <= '0;
   end
`else
   logic unused_timestamp;
   assign unused_timestamp = ^timestamp;
`endif

endmodule

// File: doc/selftrigger_readout_arbiter.md
SELFTRIGGER_READOUT_ARBITER -- requirements
Module: selftrigger_readout_arbiter

Interface
REQ-001 Parameter NCH, default 8, number of self-trigger channels (power of two, 2..16).
REQ-002 Parameter DT_W, default 16, deadtime counter width.
REQ-003 clk  input  1  clock, all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  global arm; low blocks new pending triggers.
REQ-006 trig_in  input  NCH  per-channel trigger_output from the filter/trigger channels, level.
REQ-007 ch_enable  input  NCH  per-channel arm mask.
REQ-008 deadtime  input  DT_W  holdoff cycles after an accepted trigger, sampled at acceptance.
REQ-009 timestamp  input  64  free-running timestamp.
REQ-010 rd_req  output  1  readout request to shared readout engine.
REQ-011 rd_ch  output  log2(NCH)  granted channel, valid while rd_req high.
REQ-012 rd_ack  input  1  readout engine accepted request, single-cycle pulse.
REQ-013 rd_done  input  1  readout engine finished granted record, single-cycle pulse.
REQ-014 pending  output  NCH  per-channel pending flags.
REQ-015 missed_cnt  output  16  saturating count of triggers lost because channel already pending.

Function
REQ-016 Edge detect: trigger event on channel i = trig_in[i] high this cycle, low previous cycle (registered copy).
REQ-017 Event accepted iff enable=1, ch_enable[i]=1, dt_cnt[i]=0, pending[i]=0; then pending[i]<=1, dt_cnt[i]<=deadtime next cycle.
REQ-018 Event with dt_cnt[i]!=0 ignored silently; event with pending[i]=1 and dt_cnt[i]=0 increments missed_cnt, saturating at 16'hFFFF.
REQ-019 dt_cnt[i] decrements by 1 per cycle while nonzero; deadtime=0 gives no holdoff.
REQ-020 FSM states IDLE, REQ, BUSY; reset state IDLE.
REQ-021 IDLE: if any pending bit set, select first set bit scanning upward from rr_ptr (wrapping), load rd_ch, clear that pending bit, go REQ.
REQ-022 REQ: rd_req=1, rd_ch stable; on rd_ack go BUSY with rd_req=0 the same cycle as transition.
REQ-023 BUSY: on rd_done set rr_ptr<=rd_ch+1 modulo NCH, go IDLE; rd_done in REQ or IDLE ignored.
REQ-024 Latency: trigger edge at cycle t on idle system -> pending at t+1 -> rd_req at t+2.
REQ-025 Simultaneous new accepted event and grant-clear on same channel: set wins, pending stays 1.
REQ-026 enable deassert mid-transaction: current REQ/BUSY completes; pending flags already set remain and are still served.
REQ-027 rd_req, rd_ch change only on state transitions (no glitching between channels inside REQ).

Reset
REQ-028 reset clears pending, dt_cnt, edge registers, missed_cnt, rr_ptr=0, rd_ch=0, rd_req=0, FSM=IDLE, within one clock, regardless of state.

Configuration
REQ-029 Macro SELFTRIG_TIMESTAMP_EN: when defined, per-channel 64-bit ts_reg captures timestamp at acceptance and output rd_ts (64) presents ts_reg[rd_ch] while rd_req high, reset 0.
REQ-030 Without SELFTRIG_TIMESTAMP_EN: no ts_reg storage, no rd_ts port; all other behaviour identical.

Structure
REQ-031 Shared package selftrigger_pkg holds FSM state enum, NCH default, DT_W default, missed counter width constant.
REQ-032 One sub-module rr_priority_select: combinational round-robin first-set-bit finder (request vector, pointer -> index, valid).

Verification
REQ-033 Single edge ch3, deadtime=10 -> pending[3] at t+1, rd_req with rd_ch=3 at t+2; ack, done -> IDLE, rr_ptr=4.
REQ-034 Edges ch1, ch5, ch6 same cycle, rr_ptr=0 -> grant order 1,5,6.
REQ-035 Second edge on ch2 while pending, deadtime=0 -> missed_cnt=1; edge during dt_cnt>0 -> missed_cnt unchanged.
REQ-036 70000 blocked edges with pending held -> missed_cnt saturates 16'hFFFF.
REQ-037 reset asserted in BUSY with 3 pending -> next cycle rd_req=0, pending=0, missed_cnt=0, FSM IDLE.
REQ-038 SELFTRIG_TIMESTAMP_EN defined, ch0 accepted at timestamp 1000 -> rd_ts=1000 while rd_req high.
